// File: rtl/imem_fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, reads Imem combinationally and
// buffers {pc, instruction} pairs in a prefetch FIFO with a valid/ready output.
module imem_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic                       i_clk,
   input  logic                       i_rst_n,
   input  logic                       i_fetch_en,
   output logic [31:0]                o_imem_addr,
   input  logic [31:0]                i_imem_rd,
   input  logic                       i_redirect_valid,
   input  logic [31:0]                i_redirect_pc,
   output logic                       o_instr_valid,
   input  logic                       i_instr_ready,
   output logic [31:0]                o_instr,
   output logic [31:0]                o_instr_pc,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [31:0] NOP = 32'h0000_0013;

   logic [31:0]   r_fetch_pc;
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [CW-1:0] r_count;
   logic [31:0]   r_mem_pc    [DEPTH];
   logic [31:0]   r_mem_instr [DEPTH];

   logic w_not_empty;
   logic w_pop;
   logic w_push;

   assign w_not_empty = (r_count != {CW{1'b0}});
   assign w_pop       = w_not_empty & i_instr_ready;
   // A full buffer still accepts a word when the head leaves on the same edge.
   assign w_push      = i_fetch_en & ((r_count < CW'(DEPTH)) | w_pop);

   // Fetch PC, FIFO storage, pointers and occupancy.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_fetch_pc <= RESET_PC;
         r_wr_ptr   <= {PW{1'b0}};
         r_rd_ptr   <= {PW{1'b0}};
         r_count    <= {CW{1'b0}};
         for (int i = 0; i < DEPTH; i++) begin
            r_mem_pc[i]    <= 32'h0000_0000;
            r_mem_instr[i] <= 32'h0000_0000;
         end
      end else if (i_redirect_valid) begin
         r_fetch_pc <= {i_redirect_pc[31:2], 2'b00};
         r_wr_ptr   <= {PW{1'b0}};
         r_rd_ptr   <= {PW{1'b0}};
         r_count    <= {CW{1'b0}};
      end else begin
         if (w_push) begin
            r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
            r_mem_instr[r_wr_ptr] <= i_imem_rd;
            r_wr_ptr              <= r_wr_ptr + PW'(1);
            r_fetch_pc            <= r_fetch_pc + 32'd4;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Head presentation, driven only from stored state.
   always_comb begin
      o_instr    = NOP;
      o_instr_pc = 32'h0000_0000;
      if (w_not_empty) begin
         o_instr    = r_mem_instr[r_rd_ptr];
         o_instr_pc = r_mem_pc[r_rd_ptr];
      end else begin
         o_instr    = NOP;
         o_instr_pc = 32'h0000_0000;
      end
   end

   assign o_imem_addr   = r_fetch_pc;
   assign o_instr_valid = w_not_empty;
   assign o_count       = r_count;

endmodule
